div_unit: RTL

- Multicycle signed integer divider that feeds the HI/LO path of the multicycle CPU.
- Sits directly upstream of the HI/LO select muxes. Driven by the control FSM's DivCtrl strobe.
- Produces the remainder on the HI side and the quotient on the LO side, plus done and divide-by-zero indications for the controller.
- Restoring algorithm, one quotient bit per clock.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 27 ++
 rtl/div_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the restoring divider.
// The div_unit top honours the optional DIV_UNSIGNED_EN build macro.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } div_state_e;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    // Counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract,
// and keep or restore the partial remainder.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted[WIDTH:0] - {1'b0, divisor};
        fits    = (shifted >= {2'b00, divisor});
        rem_out = fits ? diff : shifted[WIDTH:0];
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider for the HI/LO path: remainder on hi_out, quotient on lo_out.
// Define DIV_UNSIGNED_EN to add the is_unsigned port (MIPS divu behaviour).
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
`ifdef DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             use_signed;
    logic [WIDTH-1:0] dividend_abs, divisor_abs;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

`ifdef DIV_UNSIGNED_EN
    assign use_signed = ~is_unsigned;
`else
    assign use_signed = 1'b1;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // NOTE: every variable gets its default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        dividend_abs = (use_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_abs  = (use_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

        unique case (state_q)
            IDLE: begin
                // The cycle carrying done still belongs to the finishing operation.
                if (start && !done_q) begin
                    if (divisor == '0) begin
                        div_zero_d = 1'b1;
                    end else begin
                        quo_d   = dividend_abs;
                        dvs_d   = divisor_abs;
                        rem_d   = '0;
                        q_neg_d = use_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_d = use_signed & dividend[WIDTH-1];
                        cnt_d   = CNT_W'(WIDTH);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                lo_d    = q_neg_q ? -quo_q : quo_q;
                hi_d    = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule
